div_iter_multibit: RTL and testbench
====================================

// Module: div_iter_multibit
// PURPOSE
//  Parametrised iterative integer divider for the integer execute stage; successor to the single-bit radix-2 divider.
//  Retires BITS_PER_CYCLE quotient bits per cycle, handles RV32/64 M-extension corner cases (div-by-zero, signed overflow) in one cycle.
//  Adds a valid/ready result handshake so the result is held under writeback back-pressure.
//  Squashes the in-flight op on a mispredict that makes it younger than the branch.
// PARAMETERS
//  XLEN            32  operand/result width; must be divisible by BITS_PER_CYCLE
//  BITS_PER_CYCLE  2   quotient bits per iteration cycle; legal 1,2,4
//  SQN_W           7   sequence-number width (signed wrap-around compare)
//  TAG_W           7   destination tag width
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-low
//  in_valid      in   1       op offered
//  in_ready      out  1       divider idle, op accepted when in_valid&in_ready
//  in_op         in   2       0=DIV 1=DIVU 2=REM 3=REMU
//  in_a          in   XLEN    dividend
//  in_b          in   XLEN    divisor
//  in_sqn        in   SQN_W   op sequence number
//  in_tag        in   TAG_W   destination tag
//  br_taken      in   1       mispredict flush this cycle
//  br_sqn        in   SQN_W   sqN of mispredicted branch
//  out_valid     out  1       result available
//  out_ready     in   1       writeback consumes result
//  out_result    out  XLEN    quotient or remainder
//  out_sqn       out  SQN_W   sqN of result
//  out_tag       out  TAG_W   tag of result
// BEHAVIOUR
//  States: IDLE, ITER, DONE. in_ready = (state==IDLE).
//  Reset (rst==0, sync, any state): state<=IDLE, out_valid<=0, iteration count<=0; datapath regs don't-care.
//  Younger(x) := $signed(x - br_sqn) > 0. Offered op that is younger with br_taken is not accepted (no state change).
//  IDLE accept: signed ops take |a|,|b|; neg flag = a[MSB]^b[MSB] (DIV) or a[MSB] (REM); unsigned neg=0.
//   b==0: -> DONE next edge; DIV/DIVU result all-ones, REM/REMU result = in_a unmodified.
//   signed op, a==MIN_INT, b==-1: -> DONE; DIV result MIN_INT, REM result 0.
//   else -> ITER, count = XLEN/BITS_PER_CYCLE.
//  ITER: each cycle BITS_PER_CYCLE restoring steps chained combinationally (shift rem/quot left,
//   trial subtract, keep if non-negative, quotient bit = 1); count-=1; on count==1 -> DONE.
//   Partial remainder XLEN+1 bits wide; no overflow possible.
//  DONE entry registers out_result (negated if neg flag), out_sqn, out_tag; out_valid=1.
//  Latency: general op out_valid rises XLEN/BITS_PER_CYCLE+1 edges after accept edge; corner cases 1 edge.
//  DONE: outputs stable while out_valid&!out_ready; on out_valid&out_ready -> IDLE, out_valid<=0 same edge.
//   No accept in the handshake cycle (in_ready low in DONE).
//  Flush: br_taken & younger(held sqn) in ITER or DONE -> IDLE, out_valid<=0, even if out_ready=1 that cycle
//   (result dropped). Op equal to or older than br_sqn unaffected.
//  Flush and reset win over all other transitions; reset wins over flush.
// TESTING
//  XLEN=32,BPC=2: DIV -7/2 -> out_result 0xFFFFFFFD (-3), out_valid 17 edges after accept; REM -7/2 -> 0xFFFFFFFF.
//  DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU same -> 0xF; in_ready low through ITER and DONE.
//  DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0; all 1 edge after accept.
//  out_ready held 0 for 5 cycles after out_valid -> result/sqn/tag stable, single handshake, then in_ready=1.
//  Op sqn=0x7E in ITER, br_taken br_sqn=0x7D (wrapped) -> squashed, no out_valid; br_sqn=0x7E -> completes normally.
//  rst low mid-ITER and in DONE -> out_valid=0, in_ready=1 next cycle; repeat random ops for BPC=1,4 vs reference model.

Source files
------------

// File: rtl/div_iter_multibit.sv
// Iterative restoring divider: BITS_PER_CYCLE quotient bits per cycle, with RV M-extension
// corner cases resolved at accept, a valid/ready result handshake and sequence-number squash.
module div_iter_multibit #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 2,
   parameter int SQN_W          = 7,
   parameter int TAG_W          = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [SQN_W-1:0] in_sqn,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             br_taken,
   input  logic [SQN_W-1:0] br_sqn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [SQN_W-1:0] out_sqn,
   output logic [TAG_W-1:0] out_tag
);
   localparam int NITER = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(NITER + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t             state_q, state_d;
   logic               vld_q, vld_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [XLEN:0]      rem_q, rem_d;
   logic [XLEN-1:0]    quo_q, quo_d;
   logic [XLEN-1:0]    dvs_q, dvs_d;
   logic               neg_q, neg_d;
   logic               isrem_q, isrem_d;
   logic [XLEN-1:0]    res_q, res_d;
   logic [SQN_W-1:0]   sqn_q, sqn_d;
   logic [TAG_W-1:0]   tag_q, tag_d;

   logic               in_signed, in_isrem, in_young, held_young, accept;
   logic [XLEN-1:0]    a_abs, b_abs;
   logic [SQN_W-1:0]   in_diff, held_diff;
   logic [XLEN:0]      r_step, t_step;
   logic [XLEN-1:0]    q_step, fin_mag;

   assign in_signed  = ~in_op[0];
   assign in_isrem   = in_op[1];
   assign a_abs      = (in_signed && in_a[XLEN-1]) ? -in_a : in_a;
   assign b_abs      = (in_signed && in_b[XLEN-1]) ? -in_b : in_b;

   // Wrap-around age compare: x is younger when (x - br_sqn) is strictly positive as signed.
   assign in_diff    = in_sqn - br_sqn;
   assign held_diff  = sqn_q - br_sqn;
   assign in_young   = ~in_diff[SQN_W-1] && (in_diff != '0);
   assign held_young = ~held_diff[SQN_W-1] && (held_diff != '0);

   assign accept     = in_valid && (state_q == IDLE) && !(br_taken && in_young);

   always_comb begin
      r_step = rem_q;
      q_step = quo_q;
      t_step = '0;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         r_step = {r_step[XLEN-1:0], q_step[XLEN-1]};
         q_step = {q_step[XLEN-2:0], 1'b0};
         t_step = r_step - {1'b0, dvs_q};
         if (!t_step[XLEN]) begin
            r_step    = t_step;
            q_step[0] = 1'b1;
         end
      end
      fin_mag = isrem_q ? r_step[XLEN-1:0] : q_step;
   end

   always_comb begin
      state_d = state_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      neg_d   = neg_q;
      isrem_d = isrem_q;
      res_d   = res_q;
      sqn_d   = sqn_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sqn_d   = in_sqn;
               tag_d   = in_tag;
               isrem_d = in_isrem;
               if (in_b == '0) begin
                  res_d   = in_isrem ? in_a : '1;
                  vld_d   = 1'b1;
                  state_d = DONE;
               end else if (in_signed && in_a == MIN_INT && in_b == '1) begin
                  res_d   = in_isrem ? '0 : MIN_INT;
                  vld_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = a_abs;
                  dvs_d   = b_abs;
                  neg_d   = in_signed && (in_isrem ? in_a[XLEN-1] : (in_a[XLEN-1] ^ in_b[XLEN-1]));
                  cnt_d   = CNT_W'(NITER);
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            rem_d = r_step;
            quo_d = q_step;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               res_d   = neg_q ? -fin_mag : fin_mag;
               vld_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && br_taken && held_young) begin
         vld_d   = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      isrem_q <= isrem_d;
      res_q   <= res_d;
      sqn_q   <= sqn_d;
      tag_q   <= tag_d;
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = vld_q;
   assign out_result = res_q;
   assign out_sqn    = sqn_q;
   assign out_tag    = tag_q;
endmodule

// File: tb/tb_div_iter_multibit.sv
// Bench for div_iter_multibit: three instances (1/2/4 bits per cycle) share stimulus; directed
// vectors, back-pressure, squash and reset sequences, then random ops against a reference model.
module tb_div_iter_multibit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  in_op = '0;
   logic [31:0] in_a = '0, in_b = '0;
   logic [6:0]  in_sqn = '0, in_tag = '0;
   logic        br_taken = 1'b0;
   logic [6:0]  br_sqn = '0;
   logic        out_ready = 1'b0;

   logic        rdy1, rdy2, rdy4, vld1, vld2, vld4;
   logic [31:0] res1, res2, res4;
   logic [6:0]  sqn1, sqn2, sqn4, tag1, tag2, tag4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_iter_multibit #(.XLEN(32), .BITS_PER_CYCLE(1), .SQN_W(7), .TAG_W(7)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_op(in_op), .in_a(in_a),
      .in_b(in_b), .in_sqn(in_sqn), .in_tag(in_tag), .br_taken(br_taken), .br_sqn(br_sqn),
      .out_valid(vld1), .out_ready(out_ready), .out_result(res1), .out_sqn(sqn1), .out_tag(tag1));
   div_iter_multibit #(.XLEN(32), .BITS_PER_CYCLE(2), .SQN_W(7), .TAG_W(7)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op), .in_a(in_a),
      .in_b(in_b), .in_sqn(in_sqn), .in_tag(in_tag), .br_taken(br_taken), .br_sqn(br_sqn),
      .out_valid(vld2), .out_ready(out_ready), .out_result(res2), .out_sqn(sqn2), .out_tag(tag2));
   div_iter_multibit #(.XLEN(32), .BITS_PER_CYCLE(4), .SQN_W(7), .TAG_W(7)) u_d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op), .in_a(in_a),
      .in_b(in_b), .in_sqn(in_sqn), .in_tag(in_tag), .br_taken(br_taken), .br_sqn(br_sqn),
      .out_valid(vld4), .out_ready(out_ready), .out_result(res4), .out_sqn(sqn4), .out_tag(tag4));

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      case (op)
         2'd0:    return $signed(a) / $signed(b);
         2'd1:    return a / b;
         2'd2:    return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] sqn, input logic [6:0] tag, input logic [31:0] exp,
                         input int exp_lat, input int hold);
      int lat;
      int guard;
      @(negedge clk);
      chk({nm, "_inrdy"}, {31'd0, rdy1 & rdy2 & rdy4}, 32'd1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_sqn = sqn; in_tag = tag;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      chk({nm, "_busy"}, {31'd0, rdy2}, 32'd0);
      while (!vld2 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (exp_lat != 0) chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      guard = 0;
      while (!(vld1 && vld2 && vld4) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk({nm, "_vld"}, {29'd0, vld1, vld2, vld4}, 32'd7);
      chk({nm, "_res2"}, res2, exp);
      chk({nm, "_res1"}, res1, exp);
      chk({nm, "_res4"}, res4, exp);
      chk({nm, "_sqn"}, {25'd0, sqn2}, {25'd0, sqn});
      chk({nm, "_tag"}, {25'd0, tag2}, {25'd0, tag});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold"}, {31'd0, vld2}, 32'd1);
         chk({nm, "_holdres"}, res2, exp);
         chk({nm, "_holdsqntag"}, {18'd0, sqn2, tag2}, {18'd0, sqn, tag});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, "_drop"}, {29'd0, vld1, vld2, vld4}, 32'd0);
      chk({nm, "_idle"}, {29'd0, rdy1, rdy2, rdy4}, 32'd7);
   endtask

   // Offer an op, let it reach ITER/DONE, then pulse a flush with the given branch sqn.
   task automatic flush_op(input string nm, input logic [6:0] sqn, input logic [6:0] bsq, input int wait_cyc);
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1000; in_b = 32'd7; in_sqn = sqn; in_tag = 7'h11;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (wait_cyc) @(negedge clk);
      br_taken = 1'b1; br_sqn = bsq;
      @(negedge clk);
      br_taken = 1'b0;
   endtask

   vec_t vecs[14];
   int   rises;

   initial begin
      vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 17};
      vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 17};
      vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 17};
      vecs[3]  = '{2'd3, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 17};
      vecs[4]  = '{2'd0, 32'd5,         32'd0,        32'hFFFF_FFFF, 1};
      vecs[5]  = '{2'd3, 32'd5,         32'd0,        32'd5,         1};
      vecs[6]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1};
      vecs[8]  = '{2'd0, 32'd100,       32'd7,        32'd14,        17};
      vecs[9]  = '{2'd2, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 17};
      vecs[10] = '{2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 17};
      vecs[11] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        17};
      vecs[12] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        17};
      vecs[13] = '{2'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1};

      repeat (3) @(negedge clk);
      chk("reset_vld", {29'd0, vld1, vld2, vld4}, 32'd0);
      chk("reset_rdy", {29'd0, rdy1, rdy2, rdy4}, 32'd7);
      rst = 1'b1;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 7'(i), 7'(i + 40),
                vecs[i].exp, vecs[i].lat, 0);

      run_op("bp", 2'd1, 32'd1000, 32'd3, 7'h22, 7'h33, 32'd333, 17, 5);

      // Younger offered op under flush is refused.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd1; in_a = 32'd9; in_b = 32'd3; in_sqn = 7'h05; in_tag = 7'h01;
      br_taken = 1'b1; br_sqn = 7'h03;
      @(negedge clk);
      in_valid = 1'b0; br_taken = 1'b0;
      chk("refuse_rdy", {31'd0, rdy2}, 32'd1);
      chk("refuse_vld", {31'd0, vld2}, 32'd0);

      flush_op("sq7e", 7'h7E, 7'h7D, 3);
      chk("sq7e_idle", {29'd0, rdy1, rdy2, rdy4}, 32'd7);
      rises = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (vld1 || vld2 || vld4) rises++;
      end
      chk("sq7e_novld", 32'(rises), 32'd0);

      flush_op("wrap", 7'h01, 7'h7F, 2);
      chk("wrap_idle", {31'd0, rdy2}, 32'd1);

      flush_op("keep", 7'h7E, 7'h7E, 3);
      chk("keep_busy", {31'd0, rdy2}, 32'd0);
      rises = 0;
      while (!(vld1 && vld2 && vld4) && rises < 100) begin
         @(negedge clk);
         rises++;
      end
      chk("keep_res2", res2, 32'd142);
      chk("keep_res1", res1, 32'd142);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("keep_done", {31'd0, rdy2}, 32'd1);

      // Flush beats the handshake while the result is waiting in DONE.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd0; in_a = 32'd5; in_b = 32'd0; in_sqn = 7'h10; in_tag = 7'h02;
      @(negedge clk);
      in_valid = 1'b0;
      chk("dflush_vld", {31'd0, vld2}, 32'd1);
      out_ready = 1'b1; br_taken = 1'b1; br_sqn = 7'h05;
      @(negedge clk);
      out_ready = 1'b0; br_taken = 1'b0;
      chk("dflush_drop", {31'd0, vld2}, 32'd0);
      chk("dflush_idle", {31'd0, rdy2}, 32'd1);

      // Reset mid-ITER.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd1; in_a = 32'd77; in_b = 32'd5; in_sqn = 7'h20;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_iter_vld", {29'd0, vld1, vld2, vld4}, 32'd0);
      chk("rst_iter_rdy", {29'd0, rdy1, rdy2, rdy4}, 32'd7);

      // Reset while holding a result in DONE.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'd3; in_a = 32'd5; in_b = 32'd0; in_sqn = 7'h21;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst_done_pre", {31'd0, vld2}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_done_vld", {29'd0, vld1, vld2, vld4}, 32'd0);
      chk("rst_done_rdy", {29'd0, rdy1, rdy2, rdy4}, 32'd7);

      for (int i = 0; i < 24; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(1, 255));
            1:       b = $urandom;
            2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: b = (i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
         endcase
         if (i % 8 == 7) a = 32'h8000_0000;
         run_op($sformatf("rnd%0d", i), op, a, b, 7'(i), 7'(i + 3), ref_div(op, a, b), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
